// File: rtl/bcd_display_feeder_if.sv
// Handshake and display-feed bundle between a binary producer and bcd_display_feeder.
// The master drives the request side; the slave (the converter) drives the result side.
interface bcd_display_feeder_if #(
    parameter int unsigned BIN_WIDTH = 27,
    parameter int unsigned DIGITS    = 8
);
    logic                  start;
    logic [BIN_WIDTH-1:0]  bin_value;
    logic [DIGITS-1:0]     point_in;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     point;
    logic [DIGITS-1:0]     enable;

    modport master (
        output start, bin_value, point_in,
        input  busy, done, overflow, value, point, enable
    );

    modport slave (
        input  start, bin_value, point_in,
        output busy, done, overflow, value, point, enable
    );
endinterface

// File: rtl/bcd_display_feeder.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock, feeding a
// 7-segment display with packed digits, a latched point mask and a leading-zero blanking mask.
module bcd_display_feeder #(
    parameter int unsigned BIN_WIDTH   = 27,
    parameter int unsigned DIGITS      = 8,
    parameter bit          BLANK_ZEROS = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    bcd_display_feeder_if.slave bus
);
    localparam int unsigned VW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(BIN_WIDTH + 1);

    function automatic logic [63:0] max_val(input int unsigned d);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < d; i++) r = r * 64'd10;
        return r - 64'd1;
    endfunction

    localparam logic [63:0]          SAT_VAL  = max_val(DIGITS);
    localparam logic [BIN_WIDTH-1:0] SAT_LOAD = BIN_WIDTH'(SAT_VAL);
    localparam logic [DIGITS-1:0]    EN_RST   = BLANK_ZEROS ? DIGITS'(1) : {DIGITS{1'b1}};

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t               state_q, state_d;
    logic [BIN_WIDTH-1:0] shift_q, shift_d;
    logic [VW-1:0]        bcd_q, bcd_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DIGITS-1:0]    pt_q, pt_d;
    logic                 ovf_q, ovf_d;
    logic [VW-1:0]        value_q, value_d;
    logic [DIGITS-1:0]    point_q, point_d;
    logic [DIGITS-1:0]    enable_q, enable_d;
    logic                 ovfo_q, ovfo_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    logic [VW-1:0]        bcd_adj, bcd_step;
    logic [BIN_WIDTH-1:0] shift_step;
    logic [DIGITS-1:0]    en_mask;
    logic                 sat;

    // One double-dabble step: per-nibble add-3, then shift {bcd,shift} left by one.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_step   = {bcd_adj[VW-2:0], shift_q[BIN_WIDTH-1]};
        shift_step = {shift_q[BIN_WIDTH-2:0], 1'b0};
    end

    // Scan from the most significant digit so a digit lights once anything above it is nonzero.
    always_comb begin
        logic        any;
        int unsigned k;
        any     = 1'b0;
        k       = 0;
        en_mask = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            k          = DIGITS - 1 - i;
            any        = any | (|bcd_step[4*k +: 4]);
            en_mask[k] = any | (k == 0);
        end
        if (!BLANK_ZEROS) en_mask = '1;
    end

    assign sat = 64'(bus.bin_value) > SAT_VAL;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        pt_d     = pt_q;
        ovf_d    = ovf_q;
        value_d  = value_q;
        point_d  = point_q;
        enable_d = enable_q;
        ovfo_d   = ovfo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    shift_d = sat ? SAT_LOAD : bus.bin_value;
                    pt_d    = bus.point_in;
                    ovf_d   = sat;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d   = bcd_step;
                shift_d = shift_step;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(BIN_WIDTH - 1)) begin
                    value_d  = bcd_step;
                    point_d  = pt_q;
                    ovfo_d   = ovf_q;
                    enable_d = en_mask;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            pt_q     <= '0;
            ovf_q    <= 1'b0;
            value_q  <= '0;
            point_q  <= '0;
            enable_q <= EN_RST;
            ovfo_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            pt_q     <= pt_d;
            ovf_q    <= ovf_d;
            value_q  <= value_d;
            point_q  <= point_d;
            enable_q <= enable_d;
            ovfo_q   <= ovfo_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.overflow = ovfo_q;
    assign bus.value    = value_q;
    assign bus.point    = point_q;
    assign bus.enable   = enable_q;
endmodule

// File: tb/tb_bcd_display_feeder.sv
// Directed bench for bcd_display_feeder with 27-bit input and 8 digits, leading-zero blanking on.
module tb_bcd_display_feeder;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    bcd_display_feeder_if #(.BIN_WIDTH(27), .DIGITS(8)) bus ();

    bcd_display_feeder #(
        .BIN_WIDTH  (27),
        .DIGITS     (8),
        .BLANK_ZEROS(1'b1)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    // Launch one conversion and wait (bounded) for done; lat=0 means no done seen.
    task automatic do_conv(input logic [26:0] v, input logic [7:0] p,
                           output int lat, output int busy_cnt);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.bin_value = v;
        bus.point_in  = p;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        busy_cnt  = bus.busy ? 1 : 0;
        lat       = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
            if (bus.busy === 1'b1) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.bin_value = '0;
        bus.point_in  = '0;
        #12;
        checks++;
        if ({bus.busy, bus.done, bus.overflow} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000", {bus.busy, bus.done, bus.overflow});
        end
        checks++;
        if (bus.value !== 32'h0 || bus.point !== 8'h00) begin
            errors++;
            $display("FAIL reset_value: got value=%h point=%h expected 00000000/00", bus.value, bus.point);
        end
        checks++;
        if (bus.enable !== 8'h01) begin
            errors++;
            $display("FAIL reset_enable: got %h expected 01", bus.enable);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat, bc;
        do_conv(27'd65535, 8'haa, lat, bc);
        checks++;
        if (lat !== 27) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected 27", lat);
        end
        checks++;
        if (bus.value !== 32'h00065535) begin
            errors++;
            $display("FAIL basic_value: got %h expected 00065535", bus.value);
        end
        checks++;
        if (bus.enable !== 8'h1F || bus.point !== 8'haa || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL basic_masks: got en=%h pt=%h ovf=%b expected 1f/aa/0",
                     bus.enable, bus.point, bus.overflow);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b0 || bus.value !== 32'h00065535) begin
            errors++;
            $display("FAIL basic_pulse: got done=%b value=%h expected 0/00065535", bus.done, bus.value);
        end
    endtask

    task automatic test_small();
        int lat, bc;
        do_conv(27'd4, 8'h00, lat, bc);
        checks++;
        if (lat !== 27 || bc !== 27) begin
            errors++;
            $display("FAIL small4_timing: got lat=%0d busy=%0d expected 27/27", lat, bc);
        end
        checks++;
        if (bus.value !== 32'h4 || bus.enable !== 8'h01) begin
            errors++;
            $display("FAIL small4_value: got %h en=%h expected 00000004/01", bus.value, bus.enable);
        end
        do_conv(27'd5, 8'h01, lat, bc);
        checks++;
        if (lat !== 27 || bc !== 27) begin
            errors++;
            $display("FAIL small5_timing: got lat=%0d busy=%0d expected 27/27", lat, bc);
        end
        checks++;
        if (bus.value !== 32'h5 || bus.enable !== 8'h01 || bus.point !== 8'h01) begin
            errors++;
            $display("FAIL small5_value: got %h en=%h pt=%h expected 00000005/01/01",
                     bus.value, bus.enable, bus.point);
        end
    endtask

    task automatic test_wide();
        int lat, bc;
        do_conv(27'd12345678, 8'h10, lat, bc);
        checks++;
        if (bus.value !== 32'h12345678 || bus.enable !== 8'hFF) begin
            errors++;
            $display("FAIL wide_value: got %h en=%h expected 12345678/ff", bus.value, bus.enable);
        end
        do_conv(27'd0, 8'h00, lat, bc);
        checks++;
        if (bus.value !== 32'h0 || bus.enable !== 8'h01 || lat !== 27) begin
            errors++;
            $display("FAIL zero_value: got %h en=%h lat=%0d expected 00000000/01/27",
                     bus.value, bus.enable, lat);
        end
    endtask

    task automatic test_overflow();
        int lat, bc;
        do_conv(27'd99999999, 8'h00, lat, bc);
        checks++;
        if (bus.value !== 32'h99999999 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL max_exact: got %h ovf=%b expected 99999999/0", bus.value, bus.overflow);
        end
        do_conv(27'd100000000, 8'h00, lat, bc);
        checks++;
        if (bus.value !== 32'h99999999 || bus.enable !== 8'hFF || bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL sat_value: got %h en=%h ovf=%b expected 99999999/ff/1",
                     bus.value, bus.enable, bus.overflow);
        end
        do_conv(27'd86, 8'h00, lat, bc);
        checks++;
        if (bus.value !== 32'h86 || bus.overflow !== 1'b0 || bus.enable !== 8'h03) begin
            errors++;
            $display("FAIL after_sat: got %h ovf=%b en=%h expected 00000086/0/03",
                     bus.value, bus.overflow, bus.enable);
        end
    endtask

    task automatic test_start_while_busy();
        int lat, ndone;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.bin_value = 27'd65535;
        bus.point_in  = 8'h00;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat       = 0;
        ndone     = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (k == 10) begin
                bus.start     = 1'b1;
                bus.bin_value = 27'd1;
            end
            if (k == 11) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                ndone++;
                if (lat == 0) lat = k;
            end
        end
        checks++;
        if (ndone !== 1 || lat !== 27) begin
            errors++;
            $display("FAIL busy_start_done: got dones=%0d lat=%0d expected 1/27", ndone, lat);
        end
        checks++;
        if (bus.value !== 32'h00065535) begin
            errors++;
            $display("FAIL busy_start_value: got %h expected 00065535", bus.value);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        do_conv(27'd321, 8'h00, lat, bc);
        // do_conv returns while done is high; the next launch lands in that same cycle.
        do_conv(27'd999, 8'h04, lat, bc);
        checks++;
        if (lat !== 27 || bc !== 27) begin
            errors++;
            $display("FAIL b2b_timing: got lat=%0d busy=%0d expected 27/27", lat, bc);
        end
        checks++;
        if (bus.value !== 32'h999 || bus.enable !== 8'h07 || bus.point !== 8'h04) begin
            errors++;
            $display("FAIL b2b_value: got %h en=%h pt=%h expected 00000999/07/04",
                     bus.value, bus.enable, bus.point);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc, ndone;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.bin_value = 27'd12345678;
        bus.point_in  = 8'hff;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.overflow} !== 3'b000 || bus.value !== 32'h0) begin
            errors++;
            $display("FAIL midreset_state: got flags=%b value=%h expected 000/00000000",
                     {bus.busy, bus.done, bus.overflow}, bus.value);
        end
        checks++;
        if (bus.enable !== 8'h01 || bus.point !== 8'h00) begin
            errors++;
            $display("FAIL midreset_masks: got en=%h pt=%h expected 01/00", bus.enable, bus.point);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 35; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL midreset_nodone: got active cycles=%0d expected 0", ndone);
        end
        do_conv(27'd170, 8'h00, lat, bc);
        checks++;
        if (bus.value !== 32'h170 || bus.enable !== 8'h07 || lat !== 27) begin
            errors++;
            $display("FAIL post_reset: got %h en=%h lat=%0d expected 00000170/07/27",
                     bus.value, bus.enable, lat);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_small();
        test_wide();
        test_overflow();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
